// File: rtl/pe_feed_pkg.sv
// pe_feed_pkg: shared FSM state type and default widths for the PE stream feeder
package pe_feed_pkg;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_LEN_WIDTH  = 8;
  typedef enum logic [2:0] {IDLE, START, STREAM, DRAIN, DONE} feed_state_e;
endpackage

// File: rtl/pe_feed_skid.sv
// pe_feed_skid: small synchronous FIFO that absorbs buffer read latency ahead of the PE
module pe_feed_skid
  import pe_feed_pkg::*;
#(
  parameter int W     = DEF_DATA_WIDTH,
  parameter int DEPTH = 2,
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // pointer and occupancy updates; push and pop together leave the count unchanged
  always_comb begin
    wr_ptr_d = push ? nxt(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? nxt(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  // storage and pointers, cleared on reset so the head is never X
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) mem_q[wr_ptr_q] <= push_data;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = count_q == CW'(DEPTH);
  assign empty = count_q == '0;
endmodule

// File: rtl/pe_stream_feeder.sv
// pe_stream_feeder: reads a command's words from the global buffer and streams them into one PE input
// Optional PE_FEED_STRIDE_EN adds cmd_stride; otherwise consecutive addresses are read.
module pe_stream_feeder
  import pe_feed_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH,
  parameter int SKID_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_base_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  cmd_full_column,
`ifdef PE_FEED_STRIDE_EN
  input  logic [ADDR_WIDTH-1:0] cmd_stride,
`endif
  output logic                  buf_rd_en,
  output logic [ADDR_WIDTH-1:0] buf_rd_addr,
  input  logic [DATA_WIDTH-1:0] buf_rd_data,
  output logic                  pe_start_load,
  output logic                  pe_load_full_column,
  output logic [DATA_WIDTH-1:0] pe_data,
  output logic                  pe_data_en,
  input  logic                  pe_fifo_full,
  output logic                  busy,
  output logic                  done
);
  localparam int CW = $clog2(SKID_DEPTH + 1);
  localparam int OW = CW + 1;

  feed_state_e state_q, state_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d, rd_cnt_q, rd_cnt_d, tx_cnt_q, tx_cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, stride;
  logic [DATA_WIDTH-1:0] last_q, last_d, head;
  logic                  fc_q, fc_d, infl_q, infl_d;
  logic                  rd_en, pop, skid_full, skid_empty;
  logic [CW-1:0]         count;
  logic [OW-1:0]         occ;

  pe_feed_skid #(.W(DATA_WIDTH), .DEPTH(SKID_DEPTH)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (infl_q),
    .push_data (buf_rd_data),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .full      (skid_full),
    .empty     (skid_empty)
  );

`ifdef PE_FEED_STRIDE_EN
  logic [ADDR_WIDTH-1:0] stride_q, stride_d;
  assign stride_d = (cmd_ready && cmd_valid) ? cmd_stride : stride_q;
  // stride is captured together with the rest of the command
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stride_q <= '0;
    else      stride_q <= stride_d;
  end
  assign stride = stride_q;
`else
  assign stride = ADDR_WIDTH'(1);
`endif

  // a word popped this cycle frees its slot, so it is not counted against the next read
  assign pop   = !skid_empty && !pe_fifo_full;
  assign occ   = OW'(count) + OW'(infl_q) - OW'(pop);
  assign rd_en = (state_q == STREAM) && (rd_cnt_q < len_q) && (occ < OW'(SKID_DEPTH)) && !(skid_full && !pop);

  // next-state, command latching, read/transfer counters and held output word
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    fc_d     = fc_q;
    addr_d   = rd_en ? addr_q + stride : addr_q;
    rd_cnt_d = rd_cnt_q + LEN_WIDTH'(rd_en);
    tx_cnt_d = tx_cnt_q + LEN_WIDTH'(pop);
    infl_d   = rd_en;
    last_d   = pop ? head : last_q;
    case (state_q)
      IDLE: if (cmd_valid) begin
        len_d    = cmd_len;
        fc_d     = cmd_full_column;
        addr_d   = cmd_base_addr;
        rd_cnt_d = '0;
        tx_cnt_d = '0;
        state_d  = (cmd_len == '0) ? DONE : START;
      end
      START:   state_d = STREAM;
      STREAM:  state_d = (rd_cnt_d == len_q) ? DRAIN : STREAM;
      DRAIN:   state_d = (tx_cnt_d == len_q) ? DONE : DRAIN;
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers; reset abandons any transfer in progress
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      len_q    <= '0;
      fc_q     <= 1'b0;
      addr_q   <= '0;
      rd_cnt_q <= '0;
      tx_cnt_q <= '0;
      infl_q   <= 1'b0;
      last_q   <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      fc_q     <= fc_d;
      addr_q   <= addr_d;
      rd_cnt_q <= rd_cnt_d;
      tx_cnt_q <= tx_cnt_d;
      infl_q   <= infl_d;
      last_q   <= last_d;
    end
  end

  assign cmd_ready           = state_q == IDLE;
  assign busy                = state_q != IDLE;
  assign pe_start_load       = state_q == START;
  assign done                = state_q == DONE;
  assign pe_load_full_column = fc_q && (state_q inside {START, STREAM, DRAIN});
  assign buf_rd_en           = rd_en;
  assign buf_rd_addr         = addr_q;
  assign pe_data_en          = pop;
  assign pe_data             = pop ? head : last_q;
endmodule

// File: tb/tb_pe_stream_feeder.sv
// tb_pe_stream_feeder: scoreboard bench for pe_stream_feeder with directed commands
module tb_pe_stream_feeder;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_full_column = 1'b0;
  logic [7:0]  cmd_base_addr = '0, cmd_len = '0;
  logic        buf_rd_en, pe_start_load, pe_load_full_column, pe_data_en, busy, done;
  logic        pe_fifo_full = 1'b0;
  logic [7:0]  buf_rd_addr;
  logic [15:0] buf_rd_data = '0, pe_data;

  pe_stream_feeder dut (
    .clk                 (clk),
    .rst                 (rst),
    .cmd_valid           (cmd_valid),
    .cmd_ready           (cmd_ready),
    .cmd_base_addr       (cmd_base_addr),
    .cmd_len             (cmd_len),
    .cmd_full_column     (cmd_full_column),
`ifdef PE_FEED_STRIDE_EN
    .cmd_stride          (8'd1),
`endif
    .buf_rd_en           (buf_rd_en),
    .buf_rd_addr         (buf_rd_addr),
    .buf_rd_data         (buf_rd_data),
    .pe_start_load       (pe_start_load),
    .pe_load_full_column (pe_load_full_column),
    .pe_data             (pe_data),
    .pe_data_en          (pe_data_en),
    .pe_fifo_full        (pe_fifo_full),
    .busy                (busy),
    .done                (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // buffer contents: words 1..9 at 0x10..0x18, elsewhere 0xA0 followed by the address
  function automatic logic [15:0] word_at(input logic [7:0] a);
    return (a >= 8'h10 && a <= 8'h18) ? {8'h00, a - 8'h0F} : {8'hA0, a};
  endfunction

  // synchronous buffer read with one cycle of latency
  always @(posedge clk) if (buf_rd_en) buf_rd_data <= word_at(buf_rd_addr);

  logic [15:0] exp_data[$];
  logic [7:0]  exp_addr[$];
  int  errors = 0, checks = 0;
  int  starts = 0, dones = 0, reads = 0, ens = 0;
  int  done_cyc = 0, first_en_cyc = 0, last_en_cyc = 0, hs_cyc = 0;
  bit  first_pending = 0;
  logic exp_fc = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: pops expectations whenever the DUT reads or presents a word
  always @(negedge clk) if (rst) begin
    if (pe_start_load) starts++;
    if (done) begin dones++; done_cyc = cyc; end
    if (buf_rd_en) begin
      reads++;
      if (exp_addr.size() == 0) chk("rd_addr_extra", 0, 1);
      else chk("rd_addr", buf_rd_addr, exp_addr.pop_front());
    end
    if (pe_data_en) begin
      ens++;
      if (first_pending) begin first_en_cyc = cyc; first_pending = 0; end
      last_en_cyc = cyc;
      chk("no_en_while_full", pe_fifo_full, 0);
      if (exp_data.size() == 0) chk("data_extra", 0, 1);
      else chk("pe_data", pe_data, exp_data.pop_front());
    end
    if (pe_start_load || buf_rd_en || pe_data_en) chk("full_column", pe_load_full_column, exp_fc);
  end

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_start"}, pe_start_load, 0);
    chk({tag, "_fc"}, pe_load_full_column, 0);
    chk({tag, "_rd_en"}, buf_rd_en, 0);
    chk({tag, "_rd_addr"}, buf_rd_addr, 0);
    chk({tag, "_data_en"}, pe_data_en, 0);
    chk({tag, "_data"}, pe_data, 0);
  endtask

  // offer a command, push its expected reads/words, hold valid until accepted
  task automatic run_cmd(input logic [7:0] base, input logic [7:0] len, input logic fc);
    bit ok = 0;
    @(negedge clk);
    cmd_valid = 1; cmd_base_addr = base; cmd_len = len; cmd_full_column = fc;
    for (int i = 0; i < int'(len); i++) begin
      exp_addr.push_back(base + 8'(i));
      exp_data.push_back(word_at(base + 8'(i)));
    end
    for (int n = 0; n < 100 && !ok; n++) begin
      ok = cmd_ready;
      @(posedge clk); #1;
      if (!ok) @(negedge clk);
    end
    cmd_valid = 0;
    hs_cyc = cyc;
    first_pending = 1;
    exp_fc = fc;
    chk("cmd_accept", ok, 1);
  endtask

  task automatic wait_done(input int d0);
    bit got = 0;
    for (int n = 0; n < 200 && !got; n++) begin
      @(posedge clk); #1;
      got = dones > d0;
    end
    chk("done_seen", got, 1);
  endtask

  task automatic wait_ens(input int target);
    for (int n = 0; n < 100 && ens < target; n++) begin
      @(posedge clk); #1;
    end
    chk("ens_reached", ens >= target, 1);
  endtask

  int s0, d0, e0, r0;

  initial begin
    #1 chk_reset_outs("reset");
    repeat (2) @(negedge clk);
    rst = 1;

    // base 0x10, len 6, no backpressure
    s0 = starts; d0 = dones; e0 = ens;
    run_cmd(8'h10, 8'd6, 1'b0);
    wait_done(d0);
    chk("t1_starts", starts - s0, 1);
    chk("t1_words", ens - e0, 6);
    chk("t1_dones", dones - d0, 1);
    chk("t1_first_en_latency", first_en_cyc - hs_cyc, 3);
    chk("t1_done_after_last", done_cyc - last_en_cyc, 1);
    chk("t1_drained", exp_data.size(), 0);

    // same command with PE FIFO full for 10 cycles after the 2nd word
    s0 = starts; d0 = dones; e0 = ens;
    run_cmd(8'h10, 8'd6, 1'b0);
    wait_ens(e0 + 2);
    pe_fifo_full = 1;
    r0 = reads;
    repeat (10) @(posedge clk);
    #1;
    chk("t2_reads_while_full_le2", (reads - r0) <= 2, 1);
    chk("t2_stalled_words", ens - e0, 2);
    pe_fifo_full = 0;
    wait_done(d0);
    chk("t2_words", ens - e0, 6);
    chk("t2_starts", starts - s0, 1);
    chk("t2_dones", dones - d0, 1);
    chk("t2_drained", exp_data.size(), 0);

    // address wrap from 0xFE
    d0 = dones; e0 = ens;
    run_cmd(8'hFE, 8'd4, 1'b0);
    wait_done(d0);
    chk("t3_words", ens - e0, 4);
    chk("t3_addr_drained", exp_addr.size(), 0);

    // zero-length command
    s0 = starts; d0 = dones; e0 = ens; r0 = reads;
    run_cmd(8'h30, 8'd0, 1'b0);
    wait_done(d0);
    chk("t4_done_latency", done_cyc - hs_cyc, 0);
    chk("t4_starts", starts - s0, 0);
    chk("t4_reads", reads - r0, 0);
    chk("t4_words", ens - e0, 0);

    // reset after 3 of 9 words, then a fresh len 2 command
    e0 = ens;
    run_cmd(8'h10, 8'd9, 1'b1);
    wait_ens(e0 + 3);
    rst = 0;
    exp_data.delete();
    exp_addr.delete();
    exp_fc = 0;
    #1 chk_reset_outs("midreset");
    d0 = dones;
    repeat (3) @(negedge clk);
    rst = 1;
    repeat (3) @(negedge clk);
    chk("t5_no_done", dones - d0, 0);
    chk("t5_ready", cmd_ready, 1);
    d0 = dones; e0 = ens;
    run_cmd(8'h40, 8'd2, 1'b0);
    wait_done(d0);
    chk("t5_words", ens - e0, 2);
    chk("t5_dones", dones - d0, 1);

    // back-to-back commands with full_column 1 then 0
    s0 = starts; d0 = dones; e0 = ens;
    run_cmd(8'h20, 8'd3, 1'b1);
    run_cmd(8'h28, 8'd2, 1'b0);
    chk("t6_b2b_accept", hs_cyc - done_cyc, 2);
    wait_done(d0 + 1);
    chk("t6_starts", starts - s0, 2);
    chk("t6_dones", dones - d0, 2);
    chk("t6_words", ens - e0, 5);
    chk("final_data_drained", exp_data.size(), 0);
    chk("final_addr_drained", exp_addr.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
    $fatal(1);
  end
endmodule
